// File: rtl/to_lower_pkg.sv
// Shared constants and the FIFO occupancy state for the lowercase stream converter.
package to_lower_pkg;

  localparam logic [7:0]  ASCII_UPPER_A = 8'h41;
  localparam logic [7:0]  ASCII_UPPER_Z = 8'h5A;
  localparam int unsigned CASE_BIT      = 5;

  // Number of bytes currently held in the 2-entry output FIFO.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage : to_lower_pkg

// File: rtl/to_lower_stream_conv.sv
// Combinational ASCII uppercase-to-lowercase mapper; all non 'A'..'Z' bytes pass through.
module ascii_lower_conv
  import to_lower_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       conv_o
);

  // Only the 26 uppercase letters differ from their lowercase form by the case bit.
  always_comb begin
    conv_o           = (data_i >= ASCII_UPPER_A) && (data_i <= ASCII_UPPER_Z);
    data_o           = data_i;
    data_o[CASE_BIT] = data_i[CASE_BIT] | conv_o;
  end

endmodule : ascii_lower_conv

// File: rtl/to_lower_stream.sv
// Streaming ASCII to-lowercase converter with a 2-entry registered output FIFO
// and saturating accept/convert statistics counters.
module to_lower_stream
  import to_lower_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_conv,
  input  logic             out_ready,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] byte_count,
  output logic [CNT_W-1:0] conv_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  occ_e             state_q, state_d;
  logic [8:0]       head_q, head_d;   // {conv, data}; head drives the output
  logic [8:0]       tail_q, tail_d;   // second entry, only meaningful in TWO
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0] conv_cnt_q, conv_cnt_d;
  logic [7:0]       wr_data;
  logic             wr_conv;
  logic             accept;
  logic             emit;

  // Conversion happens on the FIFO write side so stored entries are already final.
  ascii_lower_conv u_conv (
    .data_i (in_data),
    .data_o (wr_data),
    .conv_o (wr_conv)
  );

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Occupancy next-state: accept adds an entry, emit removes one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = ONE;
      ONE: begin
        if (accept && !emit)      state_d = TWO;
        else if (!accept && emit) state_d = EMPTY;
      end
      TWO:     if (emit) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // Handshake outputs depend only on registered state, never on out_ready.
  always_comb begin
    in_ready  = (state_q != TWO);
    out_valid = (state_q != EMPTY);
  end

  // FIFO entry updates: new bytes land in head when it is free (or being emitted), else in tail.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    case (state_q)
      EMPTY: if (accept) head_d = {wr_conv, wr_data};
      ONE: begin
        if (accept && emit) head_d = {wr_conv, wr_data};
        else if (accept)    tail_d = {wr_conv, wr_data};
      end
      TWO:     if (emit) head_d = tail_q;
      default: head_d = head_q;
    endcase
  end

  // Head entry is visible on the outputs, so it is cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) head_q <= 9'h000;
    else     head_q <= head_d;
  end

  // Tail entry is never observed until written, so it needs no reset.
  always_ff @(posedge clk) begin
    tail_q <= tail_d;
  end

  // Counter next-state: clear wins over counting the byte accepted in the same cycle.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    conv_cnt_d = conv_cnt_q;
    if (clr_counts) begin
      byte_cnt_d = '0;
      conv_cnt_d = '0;
    end else if (accept) begin
      byte_cnt_d = sat_inc(byte_cnt_q);
      if (wr_conv) conv_cnt_d = sat_inc(conv_cnt_q);
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      conv_cnt_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      conv_cnt_q <= conv_cnt_d;
    end
  end

  assign out_data   = head_q[7:0];
  assign out_conv   = head_q[8];
  assign byte_count = byte_cnt_q;
  assign conv_count = conv_cnt_q;

endmodule : to_lower_stream

// File: tb/tb_to_lower_stream.sv
// Directed bench for to_lower_stream with a queue scoreboard and saturating counter model.
module tb_to_lower_stream;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_conv;
  logic             out_ready;
  logic             clr_counts;
  logic [CNT_W-1:0] byte_count;
  logic [CNT_W-1:0] conv_count;

  int checks = 0;
  int errors = 0;

  logic [8:0] sb[$];   // expected {conv, data} in output order
  int         m_bc = 0;
  int         m_cc = 0;
  bit         live = 0;

  to_lower_stream #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_conv   (out_conv),
    .out_ready  (out_ready),
    .clr_counts (clr_counts),
    .byte_count (byte_count),
    .conv_count (conv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ref_conv(input logic [7:0] d);
    if (d >= 8'h41 && d <= 8'h5A) return {1'b1, d | 8'h20};
    return {1'b0, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, then advance the model.
  task automatic step(input logic v, input logic [7:0] d, input logic ordy,
                      input logic clr, input logic r);
    bit acc;
    bit emt;
    in_valid   = v;
    in_data    = d;
    out_ready  = ordy;
    clr_counts = clr;
    rst        = r;
    #1;
    if (live) begin
      chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
      if (sb.size() > 0) begin
        chk("out_data", 32'(out_data), 32'(sb[0][7:0]));
        chk("out_conv", 32'(out_conv), 32'(sb[0][8]));
      end
      chk("byte_count", 32'(byte_count), 32'(m_bc));
      chk("conv_count", 32'(conv_count), 32'(m_cc));
    end
    @(posedge clk);
    if (r) begin
      sb.delete();
      m_bc = 0;
      m_cc = 0;
      live = 1;
    end else begin
      acc = v && (sb.size() < 2);
      emt = ordy && (sb.size() > 0);
      if (emt) void'(sb.pop_front());
      if (acc) sb.push_back(ref_conv(d));
      if (clr) begin
        m_bc = 0;
        m_cc = 0;
      end else if (acc) begin
        if (m_bc < CMAX) m_bc++;
        if (ref_conv(d)[8] && m_cc < CMAX) m_cc++;
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] s1 [5];
    s1 = '{8'h41, 8'h62, 8'h5A, 8'h40, 8'h5B};   // "AbZ@["

    // Reset state
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_out_conv", 32'(out_conv), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_byte_count", 32'(byte_count), 32'h0);

    // Stream "AbZ@[" with the sink always ready
    for (int i = 0; i < 5; i++) step(1'b1, s1[i], 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);
    chk("s1_byte_count", 32'(byte_count), 32'd5);
    chk("s1_conv_count", 32'(conv_count), 32'd2);

    // Back-pressure: fill to TWO, third byte refused, then release
    step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    chk("two_in_ready", 32'(in_ready), 32'h0);
    chk("two_out_data", 32'(out_data), 32'h61);
    step(1'b1, 8'h43, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Simultaneous accept and emit while in ONE
    step(1'b1, 8'h78, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h59, 1'b1, 1'b0, 1'b0);
    chk("one_out_valid", 32'(out_valid), 32'h1);
    chk("one_in_ready", 32'(in_ready), 32'h1);
    idle(2, 1'b1);

    // High-bit byte passes unchanged
    step(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    chk("hi_out_data", 32'(out_data), 32'hC1);
    chk("hi_out_conv", 32'(out_conv), 32'h0);
    idle(2, 1'b1);

    // Counter saturation, then clear colliding with an accept
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < CMAX - 1; i++) step(1'b1, 8'h4D, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("sat_byte_count", 32'(byte_count), 32'(CMAX));
    chk("sat_conv_count", 32'(conv_count), 32'(CMAX));
    step(1'b1, 8'h51, 1'b1, 1'b1, 1'b0);
    chk("clr_byte_count", 32'(byte_count), 32'h0);
    chk("clr_conv_count", 32'(conv_count), 32'h0);
    idle(3, 1'b1);

    // Reset while holding two bytes with an offer pending
    step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h45, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h46, 1'b0, 1'b0, 1'b1);
    chk("mrst_out_valid", 32'(out_valid), 32'h0);
    chk("mrst_in_ready", 32'(in_ready), 32'h1);
    chk("mrst_byte_count", 32'(byte_count), 32'h0);
    chk("mrst_conv_count", 32'(conv_count), 32'h0);
    idle(4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_to_lower_stream

// File: doc/to_lower_stream.md
TO_LOWER_STREAM -- requirements
Module: to_lower_stream

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  upstream byte present.
REQ-006 in_data  input  8  upstream ASCII byte.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 out_valid  output  1  out_data holds a converted byte.
REQ-009 out_data  output  8  converted byte.
REQ-010 out_conv  output  1  out_data was changed by conversion.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 clr_counts  input  1  synchronous clear of both counters.
REQ-013 byte_count  output  CNT_W  bytes accepted since reset or clear.
REQ-014 conv_count  output  CNT_W  bytes converted since reset or clear.

Function
REQ-015 Conversion SHALL map 8'h41..8'h5A ('A'..'Z') to the same value with bit 5 set (8'h61..8'h7A).
REQ-016 Conversion SHALL pass every other byte unchanged, including 8'h40, 8'h5B, lowercase letters and any byte with bit 7 set.
REQ-017 out_conv SHALL be 1 exactly when REQ-015 applied to that byte.
REQ-018 Accept SHALL occur when in_valid and in_ready are both 1; emit SHALL occur when out_valid and out_ready are both 1.
REQ-019 The block SHALL buffer up to 2 converted bytes in order in a 2-entry FIFO.
REQ-020 The FIFO occupancy SHALL be tracked by the states EMPTY, ONE and TWO.
REQ-021 in_ready SHALL be 1 in EMPTY and ONE and 0 in TWO.
REQ-022 in_ready SHALL be a function of registered state only (no combinational path from out_ready).
REQ-023 out_valid SHALL be 1 in ONE and TWO.
REQ-024 Latency SHALL be 1 cycle: a byte accepted in cycle N into EMPTY appears on out_data in cycle N+1.
REQ-025 The block SHALL NOT bypass the input to the output in the same cycle.
REQ-026 State transitions SHALL be:
- EMPTY: accept -> ONE.
- ONE: accept without emit -> TWO; emit without accept -> EMPTY; both -> ONE.
- TWO: emit -> ONE (no accept possible).
REQ-027 out_data and out_conv SHALL remain stable while out_valid=1 and out_ready=0.
REQ-028 byte_count SHALL increment by 1 per accept and conv_count by 1 per accept of a converted byte.
REQ-029 Both counters SHALL saturate at all-ones and never wrap.
REQ-030 When clr_counts=1 in a cycle with an accept, both counters SHALL become 0 (clear wins; that byte is not counted).
REQ-031 clr_counts SHALL NOT affect FIFO contents or the handshake.

Reset
REQ-032 On rst=1 the state SHALL become EMPTY, out_valid=0, out_data=8'h00, out_conv=0, both counters=0 and in_ready=1 from the next cycle.
REQ-033 Reset mid-stream SHALL discard buffered bytes; an accept in the rst cycle SHALL be ignored.
REQ-034 rst SHALL take priority over clr_counts and all handshakes.

Structure
REQ-035 A shared package to_lower_pkg SHALL hold:
- constants ASCII_UPPER_A=8'h41, ASCII_UPPER_Z=8'h5A, CASE_BIT=5;
- the occupancy state typedef (EMPTY/ONE/TWO).
REQ-036 The conversion SHALL be a purely combinational sub-module ascii_lower_conv (8-bit in; 8-bit out plus conv flag), instantiated once at the FIFO write side.

Verification
REQ-037 Reset then stream "AbZ@[" with out_ready=1 -> out_data 8'h61, 8'h62, 8'h7A, 8'h40, 8'h5B; out_conv 1,0,1,0,0; byte_count=5, conv_count=2.
REQ-038 Hold out_ready=0, offer 3 bytes 'A','B','C' -> 2 accepted, in_ready=0 in TWO, out_data=8'h61 stable; release -> 'a','b','c' in order.
REQ-039 In ONE, accept and emit in the same cycle -> state stays ONE, no byte lost or duplicated, count +1.
REQ-040 Input 8'hC1 -> output 8'hC1, out_conv=0.
REQ-041 Preload counters to all-ones minus 1, send 3 uppercase bytes -> both counters hold all-ones; clr_counts together with an accept -> both counters read 0 next cycle.
REQ-042 Assert rst with TWO occupancy and in_valid=1 -> next cycle out_valid=0, counters 0, in_ready=1, no stale byte emitted afterwards.
